// File: rtl/gf_mat_vec_mul_acc.sv
// GF(2^8) matrix-vector multiplier: res = M*v, or res ^= M*v in accumulate mode, N_GF byte lanes per cycle.
// Latency: o_done in cycle R*W+3 after the start sample; M/v read from 1-cycle-latency memories, result readable when idle.
module gf_mat_vec_mul_acc #(
  parameter int          MAT_ROW_SIZE_BYTES = 8,
  parameter int          MAT_COL_SIZE_BYTES = 8,
  parameter int          N_GF               = 2,
  parameter logic [8:0]  GF_POLY            = 9'h11B,
  parameter int          PROC_SIZE          = N_GF * 8,
  parameter int          WORDS_PER_ROW      = (MAT_COL_SIZE_BYTES + N_GF - 1) / N_GF,
  parameter int          RES_WORDS          = (MAT_ROW_SIZE_BYTES + N_GF - 1) / N_GF,
  localparam int         MAT_AW = (MAT_ROW_SIZE_BYTES * WORDS_PER_ROW > 1) ?
                                  $clog2(MAT_ROW_SIZE_BYTES * WORDS_PER_ROW) : 1,
  localparam int         VEC_AW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1,
  localparam int         RES_AW = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_acc_en,
  output logic [MAT_AW-1:0]    o_mat_addr,
  output logic [VEC_AW-1:0]    o_vec_addr,
  input  logic [PROC_SIZE-1:0] i_mat,
  input  logic [PROC_SIZE-1:0] i_vec,
  input  logic                 i_res_en,
  input  logic [RES_AW-1:0]    i_res_addr,
  output logic [PROC_SIZE-1:0] o_res,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int R     = MAT_ROW_SIZE_BYTES;
  localparam int C     = MAT_COL_SIZE_BYTES;
  localparam int W     = WORDS_PER_ROW;
  localparam int NB    = RES_WORDS * N_GF;
  localparam int ROW_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(R - 1);
  localparam logic [VEC_AW-1:0] LAST_WORD = VEC_AW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [ROW_W-1:0]  row_cnt;
  logic [VEC_AW-1:0] word_cnt;
  logic [MAT_AW-1:0] mat_cnt;
  logic              drain_cnt;
  logic              acc_mode;
  logic              last_pair;

  // Per-beat tags travel alongside the memory/multiply pipeline.
  logic              t1_vld, t1_first, t1_last;
  logic [ROW_W-1:0]  t1_row;
  logic              t2_vld, t2_first, t2_last;
  logic [ROW_W-1:0]  t2_row;
  logic              t3_vld, t3_first, t3_last;
  logic [ROW_W-1:0]  t3_row;

  logic [7:0]        prod_d, prod_q;
  logic [7:0]        acc_q, acc_base, acc_d;
  logic [7:0]        res_mem [NB];
  logic [PROC_SIZE-1:0] rd_word;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ GF_POLY[7:0]) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  always_comb begin
    state_d   = state_q;
    last_pair = (row_cnt == LAST_ROW) && (word_cnt == LAST_WORD);
    case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (last_pair) state_d = DRAIN;
      DRAIN:   if (drain_cnt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tail lanes past column C on a row's last word contribute nothing.
  always_comb begin
    prod_d = 8'h00;
    for (int j = 0; j < N_GF; j++) begin
      if (!(t2_last && ((W - 1) * N_GF + j >= C)))
        prod_d = prod_d ^ gf_mul(i_mat[8*j +: 8], i_vec[8*j +: 8]);
    end
  end

  always_comb begin
    acc_base = acc_q;
    if (t3_first) acc_base = acc_mode ? res_mem[t3_row] : 8'h00;
    acc_d = acc_base ^ prod_q;
  end

  always_comb begin
    rd_word = '0;
    if (int'(i_res_addr) < RES_WORDS) begin
      for (int j = 0; j < N_GF; j++)
        rd_word[8*j +: 8] = res_mem[ROW_W'(int'(i_res_addr) * N_GF + j)];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_cnt    <= '0;
      word_cnt   <= '0;
      mat_cnt    <= '0;
      drain_cnt  <= 1'b0;
      acc_mode   <= 1'b0;
      o_mat_addr <= '0;
      o_vec_addr <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      t1_vld     <= 1'b0;
      t1_first   <= 1'b0;
      t1_last    <= 1'b0;
      t1_row     <= '0;
      t2_vld     <= 1'b0;
      t2_first   <= 1'b0;
      t2_last    <= 1'b0;
      t2_row     <= '0;
      t3_vld     <= 1'b0;
      t3_first   <= 1'b0;
      t3_last    <= 1'b0;
      t3_row     <= '0;
      prod_q     <= 8'h00;
      acc_q      <= 8'h00;
    end else begin
      o_done <= 1'b0;
      t1_vld <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            acc_mode  <= i_acc_en;
            row_cnt   <= '0;
            word_cnt  <= '0;
            mat_cnt   <= '0;
            drain_cnt <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        RUN: begin
          o_mat_addr <= mat_cnt;
          o_vec_addr <= word_cnt;
          t1_vld     <= 1'b1;
          t1_first   <= (word_cnt == '0);
          t1_last    <= (word_cnt == LAST_WORD);
          t1_row     <= row_cnt;
          mat_cnt    <= mat_cnt + 1'b1;
          if (word_cnt == LAST_WORD) begin
            word_cnt <= '0;
            row_cnt  <= row_cnt + 1'b1;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        DRAIN: drain_cnt <= 1'b1;
        DONE: begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        default: ;
      endcase

      // t1 = address issued, t2 = memory data present, t3 = product registered.
      t2_vld   <= t1_vld;
      t2_first <= t1_first;
      t2_last  <= t1_last;
      t2_row   <= t1_row;
      t3_vld   <= t2_vld;
      t3_first <= t2_first;
      t3_last  <= t2_last;
      t3_row   <= t2_row;
      prod_q   <= prod_d;
      if (t3_vld) acc_q <= acc_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NB; i++) res_mem[i] <= 8'h00;
      o_res <= '0;
    end else begin
      if (t3_vld && t3_last) res_mem[t3_row] <= acc_d;
      if (i_res_en && !o_busy) o_res <= rd_word;
    end
  end

endmodule

// File: tb/tb_gf_mat_vec_mul_acc.sv
// Directed bench: two instances (N_GF=2 and N_GF=3 with padded tail), synchronous-read memory models.
module tb_gf_mat_vec_mul_acc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start2, acc2, res_en2, busy2, done2;
  logic [1:0]  res_addr2, vec_addr2;
  logic [4:0]  mat_addr2;
  logic [15:0] mat2, vec2, res2;

  logic        start3, acc3, res_en3, busy3, done3;
  logic [1:0]  res_addr3, vec_addr3;
  logic [4:0]  mat_addr3;
  logic [23:0] mat3, vec3, res3;

  logic [7:0]  mm [8][8];
  logic [7:0]  vv [8];
  logic [63:0] mt2, vt2, mt3, vt3;

  int tests = 0;
  int fails = 0;

  gf_mat_vec_mul_acc #(.MAT_ROW_SIZE_BYTES(8), .MAT_COL_SIZE_BYTES(8), .N_GF(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_acc_en(acc2),
    .o_mat_addr(mat_addr2), .o_vec_addr(vec_addr2), .i_mat(mat2), .i_vec(vec2),
    .i_res_en(res_en2), .i_res_addr(res_addr2), .o_res(res2), .o_busy(busy2), .o_done(done2)
  );

  gf_mat_vec_mul_acc #(.MAT_ROW_SIZE_BYTES(8), .MAT_COL_SIZE_BYTES(8), .N_GF(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_acc_en(acc3),
    .o_mat_addr(mat_addr3), .o_vec_addr(vec_addr3), .i_mat(mat3), .i_vec(vec3),
    .i_res_en(res_en3), .i_res_addr(res_addr3), .o_res(res3), .o_busy(busy3), .o_done(done3)
  );

  // Memory words: lanes beyond column 7 are filled with 0xFF so tail masking is exercised.
  function automatic logic [63:0] mword(input int a, input int n);
    int wpr, r, w, c;
    logic [63:0] x;
    wpr = (8 + n - 1) / n;
    r = a / wpr;
    w = a % wpr;
    x = '0;
    for (int j = 0; j < n; j++) begin
      c = w * n + j;
      x[8*j +: 8] = (c < 8 && r < 8) ? mm[r][c] : 8'hFF;
    end
    return x;
  endfunction

  function automatic logic [63:0] vword(input int a, input int n);
    int c;
    logic [63:0] x;
    x = '0;
    for (int j = 0; j < n; j++) begin
      c = a * n + j;
      x[8*j +: 8] = (c < 8) ? vv[c] : 8'hFF;
    end
    return x;
  endfunction

  always @(posedge clk) begin
    mt2 = mword(int'(mat_addr2), 2);
    vt2 = vword(int'(vec_addr2), 2);
    mt3 = mword(int'(mat_addr3), 3);
    vt3 = vword(int'(vec_addr3), 3);
    mat2 <= mt2[15:0];
    vec2 <= vt2[15:0];
    mat3 <= mt3[23:0];
    vec3 <= vt3[23:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ident();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mm[r][c] = (r == c) ? 8'h01 : 8'h00;
    for (int c = 0; c < 8; c++) vv[c] = 8'(c + 1);
  endtask

  task automatic clear_mem();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mm[r][c] = 8'h00;
    for (int c = 0; c < 8; c++) vv[c] = 8'h00;
  endtask

  task automatic drive_start(input int sel, input logic s, input logic a);
    if (sel == 2) begin start2 = s; acc2 = a; end
    else begin start3 = s; acc3 = a; end
  endtask

  // Start on edge 0, then watch 45 edges; optional restart attempt and mid-run reset.
  task automatic run(input int sel, input logic acc, input int again_cyc, input int rst_cyc,
                     input int exp_done, input string tag);
    int done_cyc;
    int pulses;
    logic d, b;
    done_cyc = -1;
    pulses = 0;
    @(negedge clk);
    drive_start(sel, 1'b1, acc);
    @(posedge clk);
    #1;
    drive_start(sel, 1'b0, ~acc);
    for (int k = 1; k <= 45; k++) begin
      drive_start(sel, k == again_cyc, 1'b1);
      @(posedge clk);
      #1;
      d = (sel == 2) ? done2 : done3;
      b = (sel == 2) ? busy2 : busy3;
      if (d) begin
        pulses++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == 1) chk({tag, "_busy"}, 32'(b), 32'd1);
      if (k == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        b = (sel == 2) ? busy2 : busy3;
        chk({tag, "_busy_in_rst"}, 32'(b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    drive_start(sel, 1'b0, 1'b0);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_pulses"}, 32'(pulses), (exp_done < 0) ? 32'd0 : 32'd1);
  endtask

  task automatic rd(input int sel, input logic [1:0] addr, input logic [23:0] exp, input string tag);
    @(negedge clk);
    if (sel == 2) begin res_en2 = 1'b1; res_addr2 = addr; end
    else begin res_en3 = 1'b1; res_addr3 = addr; end
    @(posedge clk);
    #1;
    res_en2 = 1'b0;
    res_en3 = 1'b0;
    chk(tag, (sel == 2) ? 32'(res2) : 32'(res3), 32'(exp));
  endtask

  task automatic check_ident2(input string tag);
    rd(2, 2'd0, 24'h0201, {tag, "_w0"});
    rd(2, 2'd1, 24'h0403, {tag, "_w1"});
    rd(2, 2'd2, 24'h0605, {tag, "_w2"});
    rd(2, 2'd3, 24'h0807, {tag, "_w3"});
  endtask

  initial begin
    rst_n = 1'b0;
    start2 = 1'b0; acc2 = 1'b0; res_en2 = 1'b0; res_addr2 = '0;
    start3 = 1'b0; acc3 = 1'b0; res_en3 = 1'b0; res_addr3 = '0;
    clear_mem();
    #12;
    chk("rst_res", 32'(res2), 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_done", 32'(done2), 32'd0);
    chk("rst_mat_addr", 32'(mat_addr2), 32'd0);
    chk("rst_vec_addr", 32'(vec_addr2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(2, 2'd0, 24'h0, "rst_rd0");

    set_ident();
    run(2, 1'b0, 0, 0, 35, "ident");
    check_ident2("ident");

    run(2, 1'b1, 0, 0, 35, "accum");
    for (int i = 0; i < 4; i++) rd(2, 2'(i), 24'h0, "accum_zero");

    run(2, 1'b0, 0, 0, 35, "restore");
    check_ident2("restore");

    run(2, 1'b0, 10, 0, 35, "busy_start");
    check_ident2("busy_start");

    clear_mem();
    mm[0][0] = 8'h02;
    vv[0] = 8'h80;
    run(2, 1'b0, 0, 0, 35, "red1");
    rd(2, 2'd0, 24'h001B, "red1_w0");
    rd(2, 2'd1, 24'h0000, "red1_w1");
    mm[0][0] = 8'h53;
    vv[0] = 8'hCA;
    run(2, 1'b0, 0, 0, 35, "red2");
    rd(2, 2'd0, 24'h0001, "red2_w0");
    rd(2, 2'd3, 24'h0000, "red2_w3");

    set_ident();
    run(2, 1'b0, 0, 0, 35, "pre_rst");
    run(2, 1'b0, 0, 12, -1, "rst_mid");
    for (int i = 0; i < 4; i++) rd(2, 2'(i), 24'h0, "rst_mid_zero");
    run(2, 1'b0, 0, 0, 35, "post_rst");
    check_ident2("post_rst");

    run(3, 1'b0, 0, 0, 27, "pad");
    rd(3, 2'd0, 24'h030201, "pad_w0");
    rd(3, 2'd1, 24'h060504, "pad_w1");
    rd(3, 2'd2, 24'h000807, "pad_w2");
    rd(3, 2'd3, 24'h000000, "pad_oob");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
